// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
// Sequences one checkers turn: select a piece, wait for its legal destinations,
// pick a destination, commit the move to the board writer, continue multi-jumps
// and finally hand the turn to the other player.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sel_pulse, cursor_loc debounced select press and cursor square (row=[5:3])
//   own_mask              squares holding the current player's pieces
//   gen_req, gen_chain    one-cycle move-generator request (chain = jumps only)
//   gen_done, legal_mask  generator result strobe and destination mask
//   sel_loc, sel_valid    selected source square
//   dest_mask             latched legal destinations (display highlight)
//   mv_req/src/dst/jump/cap, mv_ack   move commit handshake to board writer
//   chain                 multi-jump continuation in progress
//   turn                  current player (1 = P1, 0 = P2)
// -----------------------------------------------------------------------------
module turn_sequencer #(
   parameter bit FIRST_PLAYER = 1'b1,
   parameter int GEN_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel_pulse,
   input  logic [5:0]  cursor_loc,
   input  logic [63:0] own_mask,
   output logic        gen_req,
   output logic        gen_chain,
   input  logic        gen_done,
   input  logic [63:0] legal_mask,
   output logic [5:0]  sel_loc,
   output logic        sel_valid,
   output logic [63:0] dest_mask,
   output logic        mv_req,
   output logic [5:0]  mv_src,
   output logic [5:0]  mv_dst,
   output logic        mv_jump,
   output logic [5:0]  mv_cap,
   input  logic        mv_ack,
   output logic        chain,
   output logic        turn
);

   localparam int CW = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(GEN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN_WAIT, S_PICKED, S_COMMIT, S_TURN_END
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_gen_req, r_gen_chain, r_sel_valid, r_mv_req, r_mv_jump;
   logic          r_chain, r_turn;
   logic [5:0]    r_sel_loc, r_mv_src, r_mv_dst, r_mv_cap;
   logic [63:0]   r_dest_mask;

   logic          w_cur_own, w_cur_dest, w_jump, w_gen_end, w_gen_empty;
   logic [2:0]    w_src_row, w_dst_row, w_row_dist;
   logic [6:0]    w_sum;
   logic [5:0]    w_cap;

   assign w_cur_own  = own_mask[cursor_loc];
   assign w_cur_dest = r_dest_mask[cursor_loc];

   // Candidate move is sel_loc -> cursor_loc; a two-row step is a capture.
   assign w_src_row  = r_sel_loc[5:3];
   assign w_dst_row  = cursor_loc[5:3];
   assign w_row_dist = (w_dst_row >= w_src_row) ? (w_dst_row - w_src_row)
                                                : (w_src_row - w_dst_row);
   assign w_jump     = (w_row_dist == 3'd2);
   assign w_sum      = {1'b0, r_sel_loc} + {1'b0, cursor_loc};
   assign w_cap      = w_jump ? w_sum[6:1] : 6'd0;

   // Generator wait ends on done or timeout; a timeout looks like an empty mask.
   assign w_gen_end   = gen_done || (r_cnt == CNT_LAST);
   assign w_gen_empty = gen_done ? (legal_mask == 64'd0) : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_gen_req   <= 1'b0;
         r_gen_chain <= 1'b0;
         r_sel_loc   <= 6'd0;
         r_sel_valid <= 1'b0;
         r_dest_mask <= 64'd0;
         r_mv_req    <= 1'b0;
         r_mv_src    <= 6'd0;
         r_mv_dst    <= 6'd0;
         r_mv_jump   <= 1'b0;
         r_mv_cap    <= 6'd0;
         r_chain     <= 1'b0;
         r_turn      <= FIRST_PLAYER;
      end else begin
         // gen_req/gen_chain are single-cycle pulses
         r_gen_req   <= 1'b0;
         r_gen_chain <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (sel_pulse && w_cur_own) begin
                  r_sel_loc   <= cursor_loc;
                  r_sel_valid <= 1'b1;
                  r_gen_req   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= S_GEN_WAIT;
               end
            end
            S_GEN_WAIT: begin
               if (w_gen_end) begin
                  r_dest_mask <= gen_done ? legal_mask : 64'd0;
                  if (!w_gen_empty)
                     r_state <= S_PICKED;
                  else if (r_chain)
                     r_state <= S_TURN_END;
                  else begin
                     r_sel_valid <= 1'b0;
                     r_state     <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_PICKED: begin
               if (sel_pulse) begin
                  if (w_cur_dest) begin
                     r_mv_src  <= r_sel_loc;
                     r_mv_dst  <= cursor_loc;
                     r_mv_jump <= w_jump;
                     r_mv_cap  <= w_cap;
                     r_mv_req  <= 1'b1;
                     r_state   <= S_COMMIT;
                  end else if ((cursor_loc == r_sel_loc) && !r_chain) begin
                     r_sel_valid <= 1'b0;
                     r_dest_mask <= 64'd0;
                     r_state     <= S_IDLE;
                  end else if (w_cur_own && !r_chain) begin
                     r_sel_loc <= cursor_loc;
                     r_gen_req <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= S_GEN_WAIT;
                  end
                  // anything else (incl. leaving the jumping piece) is ignored
               end
            end
            S_COMMIT: begin
               if (mv_ack) begin
                  r_mv_req <= 1'b0;
                  if (r_mv_jump) begin
                     // continue the chain from the landing square, jumps only
                     r_sel_loc   <= r_mv_dst;
                     r_chain     <= 1'b1;
                     r_gen_req   <= 1'b1;
                     r_gen_chain <= 1'b1;
                     r_cnt       <= '0;
                     r_state     <= S_GEN_WAIT;
                  end else begin
                     r_state <= S_TURN_END;
                  end
               end
            end
            S_TURN_END: begin
               r_turn      <= ~r_turn;
               r_sel_valid <= 1'b0;
               r_chain     <= 1'b0;
               r_dest_mask <= 64'd0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gen_req   = r_gen_req;
   assign gen_chain = r_gen_chain;
   assign sel_loc   = r_sel_loc;
   assign sel_valid = r_sel_valid;
   assign dest_mask = r_dest_mask;
   assign mv_req    = r_mv_req;
   assign mv_src    = r_mv_src;
   assign mv_dst    = r_mv_dst;
   assign mv_jump   = r_mv_jump;
   assign mv_cap    = r_mv_cap;
   assign chain     = r_chain;
   assign turn      = r_turn;

endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        rst, sel_pulse, gen_done, mv_ack;
  logic [5:0]  cursor_loc;
  logic [63:0] own_mask, legal_mask;
  logic        gen_req, gen_chain, sel_valid, mv_req, mv_jump, chain, turn;
  logic [5:0]  sel_loc, mv_src, mv_dst, mv_cap;
  logic [63:0] dest_mask;

  always #5 clk = ~clk;

  turn_sequencer #(.FIRST_PLAYER(1'b1), .GEN_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .sel_pulse(sel_pulse), .cursor_loc(cursor_loc),
    .own_mask(own_mask), .gen_req(gen_req), .gen_chain(gen_chain),
    .gen_done(gen_done), .legal_mask(legal_mask), .sel_loc(sel_loc),
    .sel_valid(sel_valid), .dest_mask(dest_mask), .mv_req(mv_req),
    .mv_src(mv_src), .mv_dst(mv_dst), .mv_jump(mv_jump), .mv_cap(mv_cap),
    .mv_ack(mv_ack), .chain(chain), .turn(turn)
  );

  typedef struct {
    string       nm;
    logic        rst, sel, done, ack;
    logic [5:0]  cur;
    logic [63:0] legal;
    logic [94:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic        e_greq, e_gch, e_sv, e_mreq, e_mj, e_ch, e_trn;
  logic [5:0]  e_sl, e_ms, e_md, e_mc;
  logic [63:0] e_dm;

  function automatic logic [63:0] b64(input int i);
    return 64'd1 << i;
  endfunction

  task automatic exp_rst();
    e_greq = 0; e_gch = 0; e_sv = 0; e_mreq = 0; e_mj = 0; e_ch = 0;
    e_trn = 1; e_sl = 0; e_ms = 0; e_md = 0; e_mc = 0; e_dm = 0;
  endtask

  task automatic push(input string nm, input logic r, input logic s,
                      input logic [5:0] c, input logic d,
                      input logic [63:0] l, input logic a);
    vec_t t;
    t.nm = nm; t.rst = r; t.sel = s; t.cur = c; t.done = d; t.legal = l;
    t.ack = a;
    t.exp = {e_greq, e_gch, e_sv, e_mreq, e_mj, e_ch, e_trn,
             e_sl, e_ms, e_md, e_mc, e_dm};
    vecs.push_back(t);
  endtask

  initial begin
    logic [94:0] got;
    rst = 1; sel_pulse = 0; gen_done = 0; mv_ack = 0; cursor_loc = 0;
    legal_mask = 0;
    own_mask = b64(21) | b64(23);

    exp_rst();                         push("reset",            1,0, 0,0,0,0);
                                       push("idle_opp_ignored", 0,1,42,0,0,0);
    e_greq = 1; e_sl = 21; e_sv = 1;   push("select21",         0,1,21,0,0,0);
    e_greq = 0;                        push("genwait_sel_ign",  0,1,23,0,0,0);
    e_dm = b64(28) | b64(30);          push("gen_done_picked",  0,0, 0,1,b64(28)|b64(30),0);
    e_mreq = 1; e_ms = 21; e_md = 28;  push("commit_simple",    0,1,28,0,0,0);
    for (int k = 0; k < 5; k++)        push("commit_hold",      0,(k==2),30,0,0,0);
    e_mreq = 0;                        push("ack_simple",       0,0, 0,0,0,1);
    e_trn = 0; e_sv = 0; e_dm = 0;     push("turn_end_simple",  0,0, 0,0,0,0);

    exp_rst();                         push("reset2",           1,0, 0,0,0,0);
    e_greq = 1; e_sl = 21; e_sv = 1;   push("chain_sel21",      0,1,21,0,0,0);
    e_greq = 0; e_dm = b64(35);        push("chain_gen35",      0,0, 0,1,b64(35),0);
    e_mreq = 1; e_ms = 21; e_md = 35; e_mj = 1; e_mc = 28;
                                       push("jump_21_35",       0,1,35,0,0,0);
    e_mreq = 0; e_sl = 35; e_ch = 1; e_greq = 1; e_gch = 1;
                                       push("jump1_ack",        0,0, 0,0,0,1);
    e_greq = 0; e_gch = 0; e_dm = b64(49);
                                       push("chain_gen49",      0,0, 0,1,b64(49),1);
                                       push("chain_desel_ign",  0,1,35,0,0,0);
                                       push("chain_resel_ign",  0,1,23,0,0,0);
    e_mreq = 1; e_ms = 35; e_md = 49; e_mc = 42;
                                       push("jump_35_49",       0,1,49,0,0,0);
    e_mreq = 0; e_sl = 49; e_greq = 1; e_gch = 1;
                                       push("jump2_ack",        0,0, 0,0,0,1);
    e_greq = 0; e_gch = 0; e_dm = 0;   push("chain_empty",      0,0, 0,1,0,0);
    e_trn = 0; e_sv = 0; e_ch = 0;     push("chain_turn_end",   0,0, 0,0,0,0);

    e_greq = 1; e_sl = 21; e_sv = 1;   push("sel21_again",      0,1,21,0,0,0);
    e_greq = 0; e_dm = b64(28) | b64(30);
                                       push("gen_28_30",        0,0, 0,1,b64(28)|b64(30),0);
    e_greq = 1; e_sl = 23;             push("reselect23",       0,1,23,0,0,0);
    e_greq = 0; e_dm = b64(30);        push("gen_30",           0,0, 0,1,b64(30),0);
    e_sv = 0; e_dm = 0;                push("deselect23",       0,1,23,0,0,0);
                                       push("idle_opp_ign2",    0,1,42,0,0,0);

    e_greq = 1; e_sl = 21; e_sv = 1;   push("sel_to",           0,1,21,0,0,0);
    e_greq = 0;
    for (int k = 0; k < 15; k++)       push("to_wait",          0,0, 0,0,0,0);
    e_sv = 0;                          push("to_idle",          0,0, 0,0,0,0);
                                       push("done_outside_ign", 0,0, 0,1,b64(28),0);

    e_greq = 1; e_sl = 21; e_sv = 1;   push("csel_to",          0,1,21,0,0,0);
    e_greq = 0; e_dm = b64(35);        push("cgen_to",          0,0, 0,1,b64(35),0);
    e_mreq = 1; e_ms = 21; e_md = 35; e_mj = 1; e_mc = 28;
                                       push("cjump_to",         0,1,35,0,0,0);
    e_mreq = 0; e_sl = 35; e_ch = 1; e_greq = 1; e_gch = 1;
                                       push("cack_to",          0,0, 0,0,0,1);
    e_greq = 0; e_gch = 0;
    for (int k = 0; k < 15; k++)       push("cto_wait",         0,0, 0,0,0,0);
    e_dm = 0;                          push("cto_turn_end",     0,0, 0,0,0,0);
    e_trn = 1; e_sv = 0; e_ch = 0;     push("cto_toggle",       0,0, 0,0,0,0);

    e_greq = 1; e_sl = 21; e_sv = 1;   push("rsel",             0,1,21,0,0,0);
    e_greq = 0; e_dm = b64(28);        push("rgen",             0,0, 0,1,b64(28),0);
    e_mreq = 1; e_ms = 21; e_md = 28; e_mj = 0; e_mc = 0;
                                       push("rcommit",          0,1,28,0,0,0);
    exp_rst();                         push("rst_in_commit",    1,0, 0,0,0,0);
                                       push("opp_after_rst",    0,1,42,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      sel_pulse  = vecs[i].sel;
      cursor_loc = vecs[i].cur;
      gen_done   = vecs[i].done;
      legal_mask = vecs[i].legal;
      mv_ack     = vecs[i].ack;
      @(posedge clk);
      #1;
      got = {gen_req, gen_chain, sel_valid, mv_req, mv_jump, chain, turn,
             sel_loc, mv_src, mv_dst, mv_cap, dest_mask};
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL %s [vec %0d]: got=%h want=%h", vecs[i].nm, i, got, vecs[i].exp);
      end
      if (vecs[i].rst) begin
        total++;
        if (turn !== 1'b1 || mv_req !== 1'b0 || gen_req !== 1'b0 ||
            sel_valid !== 1'b0 || chain !== 1'b0 || sel_loc !== 6'd0 ||
            dest_mask !== 64'd0) begin
          bad++;
          $display("FAIL reset-state %s [vec %0d]: turn=%b mv_req=%b gen_req=%b sel_valid=%b",
                   vecs[i].nm, i, turn, mv_req, gen_req, sel_valid);
        end
      end
      if (vecs[i].nm == "to_idle") begin
        total++;
        if (sel_valid !== 1'b0 || gen_req !== 1'b0 || dest_mask !== 64'd0) begin
          bad++;
          $display("FAIL expired-wait [vec %0d]: sel_valid=%b gen_req=%b dest_mask=%h",
                   i, sel_valid, gen_req, dest_mask);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
